// File: rtl/lamp_pkg.sv
// Shared types and the letter-to-lamp wiring map for the Enigma lampboard sequencer.
package lamp_pkg;

  localparam int unsigned LAMP_W      = 32;
  localparam int unsigned NUM_LETTERS = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Lampboard wiring is scrambled relative to the alphabet.
  function automatic logic [LAMP_W-1:0] letter_to_lamp(input logic [4:0] idx);
    logic [4:0] bit_pos;
    if (idx >= 5'(NUM_LETTERS)) return '0;
    case (idx)
      5'd0:    bit_pos = 5'd2;
      5'd1:    bit_pos = 5'd18;
      5'd2:    bit_pos = 5'd12;
      5'd3:    bit_pos = 5'd0;
      5'd4:    bit_pos = 5'd7;
      5'd5:    bit_pos = 5'd11;
      5'd6:    bit_pos = 5'd14;
      5'd7:    bit_pos = 5'd17;
      5'd8:    bit_pos = 5'd27;
      5'd9:    bit_pos = 5'd20;
      5'd10:   bit_pos = 5'd23;
      5'd11:   bit_pos = 5'd26;
      5'd12:   bit_pos = 5'd16;
      5'd13:   bit_pos = 5'd21;
      5'd14:   bit_pos = 5'd25;
      5'd15:   bit_pos = 5'd3;
      5'd16:   bit_pos = 5'd1;
      5'd17:   bit_pos = 5'd10;
      5'd18:   bit_pos = 5'd5;
      5'd19:   bit_pos = 5'd13;
      5'd20:   bit_pos = 5'd19;
      5'd21:   bit_pos = 5'd15;
      5'd22:   bit_pos = 5'd4;
      5'd23:   bit_pos = 5'd9;
      5'd24:   bit_pos = 5'd6;
      default: bit_pos = 5'd8;
    endcase
    return {{(LAMP_W-1){1'b0}}, 1'b1} << bit_pos;
  endfunction

endpackage

// File: rtl/lamp_fifo.sv
// Small first-word-fall-through queue of 5-bit letter indices with synchronous flush.
module lamp_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [4:0]             i_wdata,
  input  logic                   i_pop,
  output logic [4:0]             o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [4:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/lamp_sequencer.sv
// Lampboard display sequencer: filters ASCII letters, queues them, and flashes
// each lamp for a fixed hold time followed by a fixed dark gap.
module lamp_sequencer
  import lamp_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 10_000_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_char,
  input  logic                        clear,
  output logic [LAMP_W-1:0]           lampboard,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic [7:0]                  err_cnt
);

  localparam int unsigned MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [LAMP_W-1:0] r_lamp;
  logic [LAMP_W-1:0] w_lamp_nxt;
  logic [7:0]        r_err;

  logic       w_full;
  logic       w_empty;
  logic [4:0] w_rdata;
  logic       w_pop;
  logic       w_xfer;
  logic       w_is_letter;
  logic       w_push;
  logic [4:0] w_idx;

  assign in_ready = !w_full && !clear;
  assign w_xfer   = in_valid && in_ready;

  // Upper and lower case share the low five bits: 'A'/'a' -> 1 ... 'Z'/'z' -> 26.
  assign w_is_letter = ((in_char >= 8'h41) && (in_char <= 8'h5A)) ||
                       ((in_char >= 8'h61) && (in_char <= 8'h7A));
  assign w_idx       = in_char[4:0] - 5'd1;
  assign w_push      = w_xfer && w_is_letter;

  assign lampboard = r_lamp;
  assign err_cnt   = r_err;
  assign busy      = (r_state != IDLE) || !w_empty;

  lamp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (clear),
    .i_push  (w_push),
    .i_wdata (w_idx),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lamp_nxt  = r_lamp;
    w_pop       = 1'b0;
    if (clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_lamp_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_lamp_nxt  = letter_to_lamp(w_rdata);
            w_cnt_nxt   = HOLD_LOAD;
            w_state_nxt = SHOW;
          end
        end
        SHOW: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else if (GAP_CYCLES > 0) begin
            w_lamp_nxt  = '0;
            w_cnt_nxt   = GAP_LOAD;
            w_state_nxt = GAP;
          end else if (!w_empty) begin
            // Zero gap: chain straight into the next letter without an IDLE bubble.
            w_pop      = 1'b1;
            w_lamp_nxt = letter_to_lamp(w_rdata);
            w_cnt_nxt  = HOLD_LOAD;
          end else begin
            w_lamp_nxt  = '0;
            w_state_nxt = IDLE;
          end
        end
        GAP: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_lamp_nxt  = letter_to_lamp(w_rdata);
            w_cnt_nxt   = HOLD_LOAD;
            w_state_nxt = SHOW;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_lamp_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lamp  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lamp  <= w_lamp_nxt;
      if (w_xfer && !w_is_letter && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
    end
  end

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed bench for lamp_sequencer with HOLD=4, GAP=2 (main) and GAP=0 (second instance).
module tb_lamp_sequencer;

  localparam logic [31:0] LAMP_A = 32'h0000_0004;
  localparam logic [31:0] LAMP_B = 32'h0004_0000;
  localparam logic [31:0] LAMP_C = 32'h0000_1000;
  localparam logic [31:0] LAMP_D = 32'h0000_0001;
  localparam logic [31:0] LAMP_E = 32'h0000_0080;
  localparam logic [31:0] LAMP_F = 32'h0000_0800;
  localparam logic [31:0] LAMP_G = 32'h0000_4000;
  localparam logic [31:0] LAMP_H = 32'h0002_0000;
  localparam logic [31:0] LAMP_L = 32'h0400_0000;
  localparam logic [31:0] LAMP_Z = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, clear, busy;
  logic [7:0]  in_char, err_cnt;
  logic [31:0] lampboard;
  logic [2:0]  level;
  logic        in_valid_g0, in_ready_g0, clear_g0, busy_g0;
  logic [7:0]  in_char_g0, err_cnt_g0;
  logic [31:0] lampboard_g0;
  logic [2:0]  level_g0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lamp_sequencer #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .clear(clear), .lampboard(lampboard), .busy(busy), .level(level), .err_cnt(err_cnt)
  );

  lamp_sequencer #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .FIFO_DEPTH(4)) u_dut_g0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_g0), .in_ready(in_ready_g0),
    .in_char(in_char_g0), .clear(clear_g0), .lampboard(lampboard_g0), .busy(busy_g0),
    .level(level_g0), .err_cnt(err_cnt_g0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  bnd [4];
    logic [31:0] rep_exp [11];
    logic [31:0] seq [4];
    bnd     = '{8'h40, 8'h5B, 8'h60, 8'h7B};
    rep_exp = '{LAMP_L, LAMP_L, LAMP_L, LAMP_L, 32'h0, 32'h0,
                LAMP_L, LAMP_L, LAMP_L, LAMP_L, 32'h0};
    seq     = '{LAMP_D, LAMP_E, LAMP_F, LAMP_G};

    rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; clear = 1'b0;
    in_valid_g0 = 1'b0; in_char_g0 = 8'h00; clear_g0 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_lamp", lampboard, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_level", {29'b0, level}, 32'h0);
    check("rst_err", {24'b0, err_cnt}, 32'h0);
    rst = 1'b0;
    #1;
    check("rst_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);

    // Single 'A'
    send(8'h41);
    check("a_level", {29'b0, level}, 32'h1);
    check("a_dark_before", lampboard, 32'h0);
    check("a_busy", {31'b0, busy}, 32'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("a_lit", lampboard, LAMP_A);
      tick();
    end
    check("a_dark_after", lampboard, 32'h0);
    check("a_busy_gap", {31'b0, busy}, 32'h1);
    tick();
    tick();
    check("a_idle", {31'b0, busy}, 32'h0);

    // Case fold and Z boundaries
    send(8'h61);
    tick();
    check("fold_a", lampboard, LAMP_A);
    repeat (6) tick();
    send(8'h7A);
    tick();
    check("fold_z", lampboard, LAMP_Z);
    repeat (6) tick();
    send(8'h5A);
    tick();
    check("upper_z", lampboard, LAMP_Z);
    repeat (6) tick();
    check("z_idle", {31'b0, busy}, 32'h0);

    // Rejections
    send(8'h31);
    check("rej_err1", {24'b0, err_cnt}, 32'h1);
    check("rej_level", {29'b0, level}, 32'h0);
    tick();
    check("rej_dark", lampboard, 32'h0);
    for (int i = 0; i < 4; i++) begin
      send(bnd[i]);
      check("bnd_level", {29'b0, level}, 32'h0);
    end
    check("bnd_err", {24'b0, err_cnt}, 32'h5);
    in_valid = 1'b1;
    in_char  = 8'h31;
    repeat (300) tick();
    in_valid = 1'b0;
    check("err_sat", {24'b0, err_cnt}, 32'hFF);
    check("rej_busy", {31'b0, busy}, 32'h0);

    // Repeated 'L' on both instances
    in_valid = 1'b1; in_char = 8'h4C;
    in_valid_g0 = 1'b1; in_char_g0 = 8'h4C;
    tick();
    tick();
    in_valid = 1'b0; in_valid_g0 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check("rep_gap2", lampboard, rep_exp[i]);
      check("rep_gap0", lampboard_g0, (i < 8) ? LAMP_L : 32'h0);
      tick();
    end
    tick();
    check("rep_idle", {31'b0, busy}, 32'h0);
    check("rep_idle_g0", {31'b0, busy_g0}, 32'h0);

    // Backpressure: B..G offered with continuous valid
    in_valid = 1'b1; in_char = 8'h42;
    check("bp_ready0", {31'b0, in_ready}, 32'h1);
    tick(); in_char = 8'h43;
    tick();
    check("bp_lamp_b", lampboard, LAMP_B);
    in_char = 8'h44;
    tick(); in_char = 8'h45;
    tick(); in_char = 8'h46;
    tick();
    check("bp_full_level", {29'b0, level}, 32'h4);
    check("bp_full_ready", {31'b0, in_ready}, 32'h0);
    in_char = 8'h47;
    tick();
    check("bp_hold_ready", {31'b0, in_ready}, 32'h0);
    check("bp_hold_level", {29'b0, level}, 32'h4);
    check("bp_gap", lampboard, 32'h0);
    tick();
    check("bp_hold_ready2", {31'b0, in_ready}, 32'h0);
    tick();
    check("bp_pop_ready", {31'b0, in_ready}, 32'h1);
    check("bp_pop_level", {29'b0, level}, 32'h3);
    check("bp_lamp_c", lampboard, LAMP_C);
    tick();
    in_valid = 1'b0;
    check("bp_sixth_level", {29'b0, level}, 32'h4);
    check("bp_lamp_c", lampboard, LAMP_C);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_lamp_c", lampboard, LAMP_C);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_gap_c", lampboard, 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        check("bp_order", lampboard, seq[k]);
      end
      for (int i = 0; i < 2; i++) begin
        tick();
        check("bp_order_gap", lampboard, 32'h0);
      end
    end
    tick();
    check("bp_idle", {31'b0, busy}, 32'h0);
    check("bp_empty", {29'b0, level}, 32'h0);

    // Clear mid-SHOW with three queued
    in_valid = 1'b1; in_char = 8'h48;
    tick(); in_char = 8'h49;
    tick(); in_char = 8'h4A;
    tick(); in_char = 8'h4B;
    tick();
    check("clr_pre_lamp", lampboard, LAMP_H);
    check("clr_pre_level", {29'b0, level}, 32'h3);
    clear = 1'b1; in_char = 8'h41;
    #1;
    check("clr_ready", {31'b0, in_ready}, 32'h0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_lamp", lampboard, 32'h0);
    check("clr_level", {29'b0, level}, 32'h0);
    check("clr_busy", {31'b0, busy}, 32'h0);
    check("clr_err", {24'b0, err_cnt}, 32'hFF);
    repeat (8) tick();
    check("clr_no_lamp", lampboard, 32'h0);
    check("clr_still_idle", {31'b0, busy}, 32'h0);

    // Asynchronous reset mid-SHOW
    in_valid = 1'b1; in_char = 8'h41;
    tick();
    tick();
    in_valid = 1'b0;
    check("ar_pre_lamp", lampboard, LAMP_A);
    check("ar_pre_level", {29'b0, level}, 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_lamp", lampboard, 32'h0);
    check("ar_busy", {31'b0, busy}, 32'h0);
    check("ar_level", {29'b0, level}, 32'h0);
    check("ar_err", {24'b0, err_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ar_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    tick();
    check("ar_stay_dark", lampboard, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
